// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 shifter.
// No logic: FSM state encoding plus default WIDTH and CS_HOLD values.
// Imported by spi_shifter; the shift register needs nothing from here.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam int SPI_WIDTH_DEF   = 8;
  localparam int SPI_CS_HOLD_DEF = 1;

endpackage

// File: rtl/spi_shift_reg.sv
// WIDTH-bit shift register shared by tx and rx: tx bits leave at one end, miso enters the other.
// Latency: load/shift take effect on the next clk edge; dout_o is the bit currently at the exit end.
// No backpressure: load has priority over shift, and both are single-cycle strobes from the controller.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_i,
  input  logic             lsb_first_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] q_o,
  output logic             dout_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: parallel load, or shift toward the exit end with din entering the far end.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_dat_i;
    end else if (shift_i) begin
      if (lsb_first_i) begin
        q_d            = q_q >> 1;
        q_d[WIDTH-1]   = din_i;
      end else begin
        q_d            = q_q << 1;
        q_d[0]         = din_i;
      end
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o    = q_q;
  assign dout_o = lsb_first_i ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: rtl/spi_shifter.sv
// SPI mode-0 master shifter driven by external sck rise/fall strobes; bit order set by SPI_SHIFTER_LSB_FIRST_EN.
// Latency: 1 fall (lead) + WIDTH rise/fall pairs + CS_HOLD rises, then done_o; all outputs registered.
// No backpressure: start_i is only accepted in IDLE outside the done cycle, otherwise it is ignored.
module spi_shifter
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH_DEF,
  parameter int CS_HOLD = SPI_CS_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck_rise_i,
  input  logic             sck_fall_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             miso_i,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             cs_n_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] rx_data_o
);

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   BITS   = CW'(WIDTH);
  localparam logic [1:0]      HOLD_N = 2'(CS_HOLD);

`ifdef SPI_SHIFTER_LSB_FIRST_EN
  localparam logic LSB_FIRST = 1'b1;
`else
  localparam logic LSB_FIRST = 1'b0;
`endif

  spi_state_e       state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [1:0]       hold_cnt_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             cs_n_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] rx_q;

  logic             accept;
  logic             fall_eff;
  logic             sr_shift;
  logic             tx_first;
  logic [WIDTH-1:0] sr_q;
  logic             sr_dout;

  // A coincident rise wins, so a fall only counts when no rise is present.
  assign fall_eff = sck_fall_i & ~sck_rise_i;
  // The done cycle sits in IDLE but must not start a new transfer.
  assign accept   = (state_q == ST_IDLE) && start_i && !done_q;
  assign sr_shift = (state_q == ST_SHIFT) && sck_rise_i && (bit_cnt_q < BITS);
  assign tx_first = LSB_FIRST ? tx_data_i[0] : tx_data_i[WIDTH-1];

  spi_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_dat_i (tx_data_i),
    .shift_i    (sr_shift),
    .lsb_first_i(LSB_FIRST),
    .din_i      (miso_i),
    .q_o        (sr_q),
    .dout_o     (sr_dout)
  );

  // Transfer sequencing and all registered bus/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (done_q) begin
            busy_q <= 1'b0;
          end else if (start_i) begin
            mosi_q     <= tx_first;
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (fall_eff) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sck_rise_i) begin
            // Counter saturates at WIDTH; a stray extra rise is ignored.
            if (bit_cnt_q < BITS) begin
              sclk_q    <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sck_fall_i) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q < BITS) begin
              mosi_q <= sr_dout;
            end else begin
              hold_cnt_q <= '0;
              state_q    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_N) begin
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            rx_q    <= sr_q;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else if (sck_rise_i) begin
            hold_cnt_q <= hold_cnt_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rx_data_o = rx_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Bench for spi_shifter: an 8-bit/CS_HOLD=1 instance and a 1-bit/CS_HOLD=0 instance share one strobe divider.
// Transfers are observed at bus level (bits sampled at each sclk rise) and compared with tx words and miso history.
// Honours SPI_SHIFTER_LSB_FIRST_EN for the expected bit order.
module tb_spi_shifter;

`ifdef SPI_SHIFTER_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rise = 1'b0, fall = 1'b0;
  logic       start8 = 1'b0, miso8 = 1'b0;
  logic [7:0] tx8 = 8'h00;
  logic       sclk8, mosi8, cs8, busy8, done8;
  logic [7:0] rx8;
  logic       start1 = 1'b0, miso1 = 1'b1;
  logic [0:0] tx1 = 1'b0;
  logic       sclk1, mosi1, cs1, busy1, done1;
  logic [0:0] rx1;

  always #5 clk = ~clk;

  spi_shifter #(.WIDTH(8), .CS_HOLD(1)) u_dut (
    .clk(clk), .rst(rst), .sck_rise_i(rise), .sck_fall_i(fall), .start_i(start8),
    .tx_data_i(tx8), .miso_i(miso8), .sclk_o(sclk8), .mosi_o(mosi8), .cs_n_o(cs8),
    .busy_o(busy8), .done_o(done8), .rx_data_o(rx8)
  );

  spi_shifter #(.WIDTH(1), .CS_HOLD(0)) u_dut1 (
    .clk(clk), .rst(rst), .sck_rise_i(rise), .sck_fall_i(fall), .start_i(start1),
    .tx_data_i(tx1), .miso_i(miso1), .sclk_o(sclk1), .mosi_o(mosi1), .cs_n_o(cs1),
    .busy_o(busy1), .done_o(done1), .rx_data_o(rx1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // strobe divider and loopback control
  int  hp = 1;
  bit  div_en = 1'b0;
  int  div_cnt = 0;
  bit  sck_lvl = 1'b0;
  bit  loop8 = 1'b1;
  int  cyc = 0;

  // bus monitor / scoreboard state
  bit          mosi_seen[$];
  bit          miso_seen[$];
  logic [31:0] q_word[$], q_seq[$], q_rxm[$], q_rxo[$];
  int          q_pul[$];
  int          gaps[$];
  logic        p_sclk8 = 1'b0, p_busy8 = 1'b0, p_sclk1 = 1'b0;
  int          pulses8 = 0, done_n8 = 0, busy_rise8 = 0, low_run = 0;
  int          cs_sclk_err = 0, busy_err = 0;
  bit          after_done = 1'b0;
  int          pulses1 = 0, done_n1 = 0, fall_cyc1 = 0, done_dly1 = 0;
  logic        rx1_at_done = 1'b0;

  // Bits in the order they crossed the wire, placed into word positions.
  function automatic logic [31:0] pack_bits(input bit b[$], input bit lsb);
    logic [31:0] w;
    int n;
    w = '0;
    n = b.size();
    for (int i = 0; i < n; i++) begin
      if (lsb) w[i] = b[i];
      else     w[n-1-i] = b[i];
    end
    return w;
  endfunction

  task automatic clear_mon();
    mosi_seen.delete(); miso_seen.delete();
    q_word.delete(); q_seq.delete(); q_rxm.delete(); q_rxo.delete(); q_pul.delete(); gaps.delete();
    pulses8 = 0; done_n8 = 0; busy_rise8 = 0; low_run = 0; after_done = 1'b0;
    pulses1 = 0; done_n1 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sclk8 && cs8) cs_sclk_err++;
    if (sclk1 && cs1) cs_sclk_err++;
    if (sclk8 && !p_sclk8) begin
      pulses8++;
      mosi_seen.push_back(mosi8);
      miso_seen.push_back(miso8);
    end
    if (done8) begin
      done_n8++;
      if (!busy8) busy_err++;
      q_word.push_back(pack_bits(mosi_seen, LSB));
      q_seq.push_back(pack_bits(mosi_seen, 1'b1));
      q_rxm.push_back(pack_bits(miso_seen, LSB));
      q_rxo.push_back(32'(rx8));
      q_pul.push_back(mosi_seen.size());
      mosi_seen.delete();
      miso_seen.delete();
      after_done = 1'b1;
    end
    if (!busy8) low_run++;
    if (busy8 && !p_busy8) begin
      busy_rise8++;
      if (after_done) gaps.push_back(low_run);
      after_done = 1'b0;
    end
    if (busy8) low_run = 0;
    p_sclk8 = sclk8;
    p_busy8 = busy8;
    if (sclk1 && !p_sclk1) pulses1++;
    if (!sclk1 && p_sclk1) fall_cyc1 = cyc;
    if (done1) begin
      done_n1++;
      rx1_at_done = rx1[0];
      done_dly1 = cyc - fall_cyc1;
    end
    p_sclk1 = sclk1;
    // inputs for the next edge
    rise = 1'b0;
    fall = 1'b0;
    if (div_en) begin
      div_cnt++;
      if (div_cnt >= hp) begin
        div_cnt = 0;
        sck_lvl = ~sck_lvl;
        if (sck_lvl) rise = 1'b1;
        else         fall = 1'b1;
      end
    end
    miso8 = loop8 ? mosi8 : 1'($urandom_range(0, 1));
  endtask

  task automatic xfer8(input logic [7:0] tx);
    start8 = 1'b1;
    tx8 = tx;
    step();
    start8 = 1'b0;
    tx8 = 8'($urandom);
  endtask

  task automatic wait_done8(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_n8;
    n = 0;
    while (done_n8 == d0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, done_n8 - d0, 1);
    step();
    step();
  endtask

  // Pops the oldest finished transfer and checks word, rx and pulse count.
  task automatic check_last(input string tag, input logic [7:0] tx, input logic [31:0] exp_rx);
    check({tag, "_rec"}, q_word.size(), 1);
    if (q_word.size() > 0) begin
      check({tag, "_txword"}, q_word.pop_front(), 32'(tx));
      check({tag, "_rx"}, q_rxo.pop_front(), exp_rx);
      check({tag, "_pulses"}, q_pul.pop_front(), 8);
      void'(q_rxm.pop_front());
      void'(q_seq.pop_front());
    end
  endtask

  initial begin
    int bad;
    int n;
    logic [7:0] tx;
    logic [31:0] rxm;

    // reset state
    repeat (3) step();
    check("rst_sclk", 32'(sclk8), 0);
    check("rst_mosi", 32'(mosi8), 0);
    check("rst_cs", 32'(cs8), 1);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_rx", 32'(rx8), 0);
    check("rst_cs1", 32'(cs1), 1);
    check("rst_rx1", 32'(rx1), 0);
    rst = 1'b0;
    step();

    // 0xA5 looped back at divide-by-2
    clear_mon();
    hp = 1; div_en = 1'b1; loop8 = 1'b1;
    xfer8(8'hA5);
    wait_done8("a5", 200);
    check("a5_seq", q_seq.size() > 0 ? q_seq[0] : 32'hFFFF_FFFF, 32'h0000_00A5);
    check("a5_ndone", done_n8, 1);
    check_last("a5", 8'hA5, 32'h0000_00A5);

    // 0x01: first bit on the wire depends on bit order
    clear_mon();
    xfer8(8'h01);
    wait_done8("x01", 200);
    check("x01_seq", q_seq.size() > 0 ? q_seq[0] : 32'hFFFF_FFFF, LSB ? 32'h01 : 32'h80);
    check_last("x01", 8'h01, 32'h01);

    // random words, random divider rates, random miso
    loop8 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clear_mon();
      hp = $urandom_range(1, 3);
      tx = 8'($urandom);
      xfer8(tx);
      wait_done8("rnd", 400);
      rxm = q_rxm.size() > 0 ? q_rxm[0] : 32'hFFFF_FFFF;
      check_last("rnd", tx, rxm);
    end

    // simultaneous rise+fall in SHIFT acts as a rise
    clear_mon();
    loop8 = 1'b1; div_en = 1'b0;
    step();
    xfer8(8'h5A);
    fall = 1'b1;
    step();
    rise = 1'b1; fall = 1'b1;
    step();
    check("both_sclk", 32'(sclk8), 1);
    check("both_pulses", pulses8, 1);
    fall = 1'b1;
    step();
    check("both_fall_sclk", 32'(sclk8), 0);
    hp = 1; div_cnt = 0; sck_lvl = 1'b0; div_en = 1'b1;
    wait_done8("both", 200);
    check_last("both", 8'h5A, 32'h5A);

    // start held for 200 cycles
    clear_mon();
    hp = 1; loop8 = 1'b1;
    tx8 = 8'h3C;
    start8 = 1'b1;
    repeat (200) step();
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 100) begin step(); n++; end
    check("held_drained", 32'(busy8), 0);
    step(); step();
    check("held_enough", 32'(done_n8 >= 5), 1);
    check("held_rises", busy_rise8, done_n8);
    bad = 0;
    foreach (gaps[i]) if (gaps[i] != 1) bad++;
    check("held_gaps", bad, 0);
    bad = 0;
    foreach (q_word[i]) if (q_word[i] != 32'h3C || q_rxo[i] != 32'h3C || q_pul[i] != 8) bad++;
    check("held_words", bad, 0);

    // reset after the 3rd rising strobe
    clear_mon();
    loop8 = 1'b0;
    xfer8(8'hFF);
    n = 0;
    while (pulses8 < 3 && n < 100) begin step(); n++; end
    check("abort_pulses", pulses8, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_cs", 32'(cs8), 1);
    check("abort_sclk", 32'(sclk8), 0);
    check("abort_busy", 32'(busy8), 0);
    check("abort_rx", 32'(rx8), 0);
    check("abort_done", 32'(done8), 0);
    repeat (40) step();
    check("abort_nodone", done_n8, 0);
    check("abort_cs_later", 32'(cs8), 1);

    // WIDTH=1, CS_HOLD=0, miso held high
    clear_mon();
    hp = 3; miso1 = 1'b1;
    start1 = 1'b1; tx1 = 1'b0;
    step();
    start1 = 1'b0;
    n = 0;
    while (done_n1 == 0 && n < 200) begin step(); n++; end
    check("w1_done", done_n1, 1);
    check("w1_pulses", pulses1, 1);
    check("w1_rx", 32'(rx1_at_done), 1);
    check("w1_dly", 32'(done_dly1 <= 2), 1);
    repeat (4) step();
    check("w1_busy_off", 32'(busy1), 0);

    check("cs_sclk_inv", cs_sclk_err, 0);
    check("busy_at_done", busy_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
